// File: rtl/key_filter_pkg.sv
// Shared constants and helpers for the multi-channel key debouncer.
package key_filter_pkg;

    localparam int CNT_MAX_20MS_50M = 999_999;
    localparam int LONG_MAX_1S_50M  = 49_999_999;

    // Pin level of a key that is not pressed: high for active-low boards.
    function automatic logic released_level(input logic active_low);
        released_level = active_low;
    endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-flop synchroniser, both-edge debounce, press/release pulses.
// Long-press pulse is built only when KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int CNT_MAX    = CNT_MAX_20MS_50M,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_W     = 26,
    parameter int LONG_MAX   = LONG_MAX_1S_50M
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic press_flag,
    output logic release_flag,
    output logic long_flag
);

    localparam logic             REL_LVL   = released_level(ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    logic [1:0]       sync_r;
    logic             key_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             key_state_r;
    logic             key_state_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             release_r;
    logic             release_nxt_s;

    assign key_s = (ACTIVE_LOW != 0) ? ~sync_r[1] : sync_r[1];

    // Debounce decision: any agreement restarts the window, a full window commits.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        key_state_nxt_s = key_state_r;
        press_nxt_s     = 1'b0;
        release_nxt_s   = 1'b0;
        if (key_s == key_state_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r < CNT_MAX_C) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s       = {CNT_W{1'b0}};
            key_state_nxt_s = key_s;
            press_nxt_s     = key_s;
            release_nxt_s   = ~key_s;
        end
    end

    // Synchroniser, counter and debounced state registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_r      <= {2{REL_LVL}};
            cnt_r       <= {CNT_W{1'b0}};
            key_state_r <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
        end else begin
            sync_r      <= {sync_r[0], key_in};
            cnt_r       <= cnt_nxt_s;
            key_state_r <= key_state_nxt_s;
            press_r     <= press_nxt_s;
            release_r   <= release_nxt_s;
        end
    end

    assign key_state    = key_state_r;
    assign press_flag   = press_r;
    assign release_flag = release_r;

`ifdef KEY_FILTER_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX_C = LONG_W'(LONG_MAX);

    logic [LONG_W-1:0] lcnt_r;
    logic [LONG_W-1:0] lcnt_nxt_s;
    logic              long_r;
    logic              long_nxt_s;

    // Hold-time counter saturates at the threshold so each press pulses once.
    always_comb begin
        lcnt_nxt_s = lcnt_r;
        long_nxt_s = 1'b0;
        if (!key_state_r) begin
            lcnt_nxt_s = {LONG_W{1'b0}};
        end else if (lcnt_r < LONG_MAX_C) begin
            lcnt_nxt_s = lcnt_r + LONG_W'(1);
            long_nxt_s = (lcnt_nxt_s == LONG_MAX_C);
        end else begin
            lcnt_nxt_s = lcnt_r;
        end
    end

    // Long-press counter and pulse registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lcnt_r <= {LONG_W{1'b0}};
            long_r <= 1'b0;
        end else begin
            lcnt_r <= lcnt_nxt_s;
            long_r <= long_nxt_s;
        end
    end

    assign long_flag = long_r;
`else
    assign long_flag = 1'b0;
`endif

endmodule

// File: rtl/key_filter_multi.sv
// Key bank debouncer: KEY_NUM independent key_filter_chan instances.
// Optional long-press pulse enabled by defining KEY_FILTER_LONG_PRESS_EN.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int KEY_NUM    = 4,
    parameter int CNT_W      = 20,
    parameter int CNT_MAX    = CNT_MAX_20MS_50M,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_W     = 26,
    parameter int LONG_MAX   = LONG_MAX_1S_50M
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_filter_chan #(
            .CNT_W      (CNT_W),
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_W     (LONG_W),
            .LONG_MAX   (LONG_MAX)
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .key_in       (key_in[i]),
            .key_state    (key_state[i]),
            .press_flag   (press_flag[i]),
            .release_flag (release_flag[i]),
            .long_flag    (long_flag[i])
        );
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Randomised + directed bench for key_filter_multi with a run-length reference model.
module tb_key_filter_multi;

    localparam int KN       = 4;
    localparam int CNT_MAX  = 9;
    localparam int LONG_MAX = 30;

    typedef struct packed {
        logic [KN-1:0] kst;
        logic [KN-1:0] prs;
        logic [KN-1:0] rel;
        logic [KN-1:0] lng;
    } exp_t;

    logic          sys_clk;
    logic          sys_rst;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_state;
    logic [KN-1:0] press_flag;
    logic [KN-1:0] release_flag;
    logic [KN-1:0] long_flag;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    exp_t exp_q[$];

    // Reference state: pressed-normalised pipeline, stable state, mismatch run, hold time.
    bit p1[KN];
    bit p2[KN];
    bit st[KN];
    int run[KN];
    int held[KN];

    key_filter_multi #(
        .KEY_NUM    (KN),
        .CNT_W      (8),
        .CNT_MAX    (CNT_MAX),
        .ACTIVE_LOW (1),
        .LONG_W     (8),
        .LONG_MAX   (LONG_MAX)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .key_state    (key_state),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Model: a level change is accepted once it has disagreed with the stable
    // state for CNT_MAX+1 consecutive edges, seen through a two-edge delay.
    task automatic model_step();
        exp_t e;
        bit   ks;
        bit   prev;
        e = '0;
        for (int c = 0; c < KN; c++) begin
            if (sys_rst) begin
                p1[c] = 1'b0; p2[c] = 1'b0; st[c] = 1'b0;
                run[c] = 0; held[c] = 0;
            end else begin
                ks    = p2[c];
                prev  = st[c];
                p2[c] = p1[c];
                p1[c] = (key_in[c] == 1'b0);
                if (ks == st[c]) begin
                    run[c] = 0;
                end else begin
                    run[c] = run[c] + 1;
                    if (run[c] == CNT_MAX + 1) begin
                        st[c]    = ks;
                        run[c]   = 0;
                        e.prs[c] = ks;
                        e.rel[c] = !ks;
                    end
                end
`ifdef KEY_FILTER_LONG_PRESS_EN
                if (!prev) held[c] = 0;
                else if (held[c] < LONG_MAX) begin
                    held[c] = held[c] + 1;
                    if (held[c] == LONG_MAX) e.lng[c] = 1'b1;
                end
`else
                held[c] = prev ? held[c] + 1 : 0;
`endif
            end
            e.kst[c] = st[c];
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge sys_clk);
            cycle = cycle + 1;
            model_step();
        end
    end

    // Monitor: compare DUT outputs against the scoreboard every cycle.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {key_state, press_flag, release_flag, long_flag};
                tests = tests + 1;
                if (a !== e) begin
                    fails = fails + 1;
                    $display("FAIL scoreboard cycle %0d: got st/pr/rl/lg=%h, want %h", cycle, a, e);
                end
            end
        end
    end

    // Count edges from the first sampling edge until the selected pulse appears.
    task automatic wait_flag(input int kind, input int ch, input int exp_n, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 45) begin
            @(posedge sys_clk);
            #1;
            n = n + 1;
            case (kind)
                0:       seen = press_flag[ch];
                1:       seen = release_flag[ch];
                2:       seen = long_flag[ch];
                default: seen = 1'b0;
            endcase
        end
        tests = tests + 1;
        if (!seen || n != exp_n) begin
            fails = fails + 1;
            $display("FAIL %s: pulse seen=%0d after %0d edges, want pulse after %0d", name, seen, n, exp_n);
        end
    endtask

    initial begin
        int hold[KN];
        sys_rst = 1'b1;
        key_in  = {KN{1'b1}};
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        key_in[0] = 1'b0;
        wait_flag(0, 0, 12, "clean_press_ch0");
        tests = tests + 1;
        if (key_state[0] !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL clean_press_state: got %b want 1", key_state[0]);
        end
`ifdef KEY_FILTER_LONG_PRESS_EN
        wait_flag(2, 0, LONG_MAX, "long_press_ch0");
`else
        repeat (LONG_MAX) @(posedge sys_clk);
`endif
        repeat (25) @(negedge sys_clk);

        key_in[1] = 1'b0;
        repeat (5) @(negedge sys_clk);
        key_in[1] = 1'b1;
        repeat (2) @(negedge sys_clk);
        key_in[1] = 1'b0;
        wait_flag(0, 1, 12, "bounce_press_ch1");

        @(negedge sys_clk);
        key_in[0] = 1'b1;
        wait_flag(1, 0, 12, "release_ch0");
        tests = tests + 1;
        if (key_state[0] !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL release_state: got %b want 0", key_state[0]);
        end

        @(negedge sys_clk);
        key_in[3:2] = 2'b00;
        wait_flag(0, 2, 12, "simul_press_ch2");
        tests = tests + 1;
        if (press_flag !== 4'b1100) begin
            fails = fails + 1;
            $display("FAIL simul_press_vec: got %b want 1100", press_flag);
        end

        @(negedge sys_clk);
        key_in[0] = 1'b0;
        repeat (7) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        tests = tests + 1;
        if ({key_state, press_flag, release_flag, long_flag} !== 16'h0000) begin
            fails = fails + 1;
            $display("FAIL reset_mid_op: got %h want 0000",
                     {key_state, press_flag, release_flag, long_flag});
        end
        sys_rst = 1'b0;
        wait_flag(0, 0, 12, "press_after_reset");

        for (int c = 0; c < KN; c++) hold[c] = 1;
        for (int t = 0; t < 2500; t++) begin
            @(negedge sys_clk);
            sys_rst = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < KN; c++) begin
                hold[c] = hold[c] - 1;
                if (hold[c] <= 0) begin
                    key_in[c] = $urandom_range(0, 1) == 1;
                    hold[c]   = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60)
                                                            : $urandom_range(1, 14);
                end
            end
        end

        @(negedge sys_clk);
        sys_rst = 1'b0;
        key_in  = {KN{1'b1}};
        repeat (30) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
